// File: rtl/alu4_arbiter.sv
// alu4_arbiter: round-robin, burst-locking front end sharing one combinational
// alu4 core between NREQ requesters, with a one-entry valid/ready response buffer.
// Optional build macro ALU4_ARB_PIPE_EN registers the operand word onto alu_in
// through an extra operand stage (response latency 2 instead of 1).
module alu4_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAXBEAT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [14*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [13:0]              alu_in,
  input  logic [7:0]               alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_last,
  output logic                     rsp_trunc
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned OPW = 14;
  localparam int unsigned BCW = 8;  // beat counter, MAXBEAT <= 255

  typedef enum logic [0:0] {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [BCW-1:0]  beat_q, beat_d;

  logic            pick_found_c;
  logic [IDW-1:0]  pick_idx_c;
  logic [IDW-1:0]  cand_c;
  logic [OPW-1:0]  sel_data_c;
  logic            sel_last_c;
  logic            space_c;
  logic            xfer_c;
  logic            end_c;
  logic            trunc_c;

  // First valid requester at or after ptr, cyclic (NREQ is a power of two)
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    cand_c       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_c = ptr_q + IDW'(i);
      if (!pick_found_c && req_valid[cand_c]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand_c;
      end
    end
  end

  // Operand word and last flag of the granted requester
  always_comb begin
    sel_data_c = '0;
    sel_last_c = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_q == IDW'(k)) begin
        sel_data_c = req_data[k*OPW +: OPW];
        sel_last_c = req_last[k];
      end
    end
  end

  // Burst closes on req_last or when this beat reaches MAXBEAT
  assign trunc_c = !sel_last_c && (beat_q == BCW'(MAXBEAT - 1));
  assign end_c   = sel_last_c || (beat_q == BCW'(MAXBEAT - 1));

  // Arbitration state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state, grant handshake and beat accounting
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    req_ready = '0;
    xfer_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found_c) begin
          grant_d = pick_idx_c;
          beat_d  = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        req_ready[grant_q] = space_c;
        xfer_c             = space_c && req_valid[grant_q];
        if (xfer_c) begin
          if (end_c) begin
            beat_d  = '0;
            ptr_d   = grant_q + IDW'(1);
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU4_ARB_PIPE_EN
  logic            op_valid_q;
  logic [IDW-1:0]  op_id_q;
  logic            op_last_q;
  logic            op_trunc_q;
  logic            op_move_c;

  // Operand stage advances whenever the response buffer is empty or popping
  assign op_move_c = op_valid_q && (!rsp_valid || rsp_ready);
  assign space_c   = !(op_valid_q && rsp_valid && !rsp_ready);

  // Operand stage: alu_in holds the word while it is presented, else zero
  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_q <= 1'b0;
      alu_in     <= '0;
      op_id_q    <= '0;
      op_last_q  <= 1'b0;
      op_trunc_q <= 1'b0;
    end else if (xfer_c) begin
      op_valid_q <= 1'b1;
      alu_in     <= sel_data_c;
      op_id_q    <= grant_q;
      op_last_q  <= end_c;
      op_trunc_q <= trunc_c;
    end else if (op_move_c) begin
      op_valid_q <= 1'b0;
      alu_in     <= '0;
    end
  end

  // Response buffer captures the ALU result of the presented operand
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_last  <= 1'b0;
      rsp_trunc <= 1'b0;
    end else if (op_move_c) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_out;
      rsp_id    <= op_id_q;
      rsp_last  <= op_last_q;
      rsp_trunc <= op_trunc_q;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
`else
  assign space_c = !rsp_valid || rsp_ready;
  assign alu_in  = xfer_c ? sel_data_c : '0;

  // Response buffer captures the ALU result in the transfer cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_last  <= 1'b0;
      rsp_trunc <= 1'b0;
    end else if (xfer_c) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_out;
      rsp_id    <= grant_q;
      rsp_last  <= end_c;
      rsp_trunc <= trunc_c;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu4_arbiter.sv
// Self-checking bench for alu4_arbiter: directed scenarios plus randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_alu4_arbiter;

  localparam int NREQ    = 4;
  localparam int MAXBEAT = 8;
`ifdef ALU4_ARB_PIPE_EN
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
`else
  localparam int LAT   = 1;
  localparam int DEPTH = 1;
`endif

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [14*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [13:0]       alu_in;
  logic [7:0]        alu_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic [1:0]        rsp_id;
  logic              rsp_last;
  logic              rsp_trunc;

  alu4_arbiter #(.NREQ(NREQ), .MAXBEAT(MAXBEAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .alu_in(alu_in), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_last(rsp_last), .rsp_trunc(rsp_trunc)
  );

  // Stand-in for the alu4 core: any fixed combinational 14->8 function
  function automatic logic [7:0] alu_ref(input logic [13:0] x);
    return (x[13:6] + (8'(x[5:0]) * 8'd5)) ^ {x[0], x[13:7]};
  endfunction

  assign alu_out = alu_ref(alu_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [13:0] word; logic last; } beat_t;
  typedef struct {
    logic [7:0]  data;
    int          id;
    logic        last;
    logic        trunc;
    int          t;
    logic [13:0] word;
  } rsp_t;

  beat_t src [NREQ][$];
  rsp_t  exp_q[$];
  int    tr_id[$];
  int    tr_cyc[$];

  logic [NREQ-1:0] en;
  logic            rr;
  bit              live;
  int              cyc;
  int              ncmp, nfail;
  int              n_pop3, n_trunc;

  bit m_busy;
  int m_g, m_ptr, m_beats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int k, input int n, input bit with_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.word = 14'($urandom);
      b.last = with_last && (i == n - 1);
      src[k].push_back(b);
    end
  endtask

  // Drive requester heads and rsp_ready, then let logic settle
  task automatic prep();
    for (int k = 0; k < NREQ; k++) begin
      if (src[k].size() > 0 && en[k]) begin
        req_valid[k]          = 1'b1;
        req_last[k]           = src[k][0].last;
        req_data[14*k +: 14]  = src[k][0].word;
      end else begin
        req_valid[k]          = 1'b0;
        req_last[k]           = 1'($urandom_range(0, 1));
        req_data[14*k +: 14]  = 14'($urandom);
      end
    end
    rsp_ready = rr;
    #3;
  endtask

  // Compare DUT against the model for this cycle, advance the model, clock
  task automatic fin();
    logic [NREQ-1:0] exp_rdy;
    logic [13:0]     exp_alu;
    bit              vis, pop, space, xfer, fin_burst;
    int              op_i;
    rsp_t            r;
    exp_rdy = '0;
    vis     = (exp_q.size() > 0) && (cyc >= exp_q[0].t + LAT);
    pop     = vis && rsp_ready;
    space   = (exp_q.size() < DEPTH) || pop;
    if (m_busy && space) exp_rdy[m_g] = 1'b1;
    xfer    = m_busy && space && req_valid[m_g];
`ifdef ALU4_ARB_PIPE_EN
    op_i    = vis ? 1 : 0;
    exp_alu = (exp_q.size() > op_i) ? exp_q[op_i].word : 14'h0;
`else
    exp_alu = xfer ? req_data[14*m_g +: 14] : 14'h0;
`endif
    if (live) begin
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("alu_in", 32'(alu_in), 32'(exp_alu));
      chk("rsp_valid", 32'(rsp_valid), 32'(vis));
      if (vis) begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
        chk("rsp_last", 32'(rsp_last), 32'(exp_q[0].last));
        chk("rsp_trunc", 32'(rsp_trunc), 32'(exp_q[0].trunc));
      end
    end
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < NREQ; k++) src[k].delete();
      m_busy = 1'b0; m_g = 0; m_ptr = 0; m_beats = 0;
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (req_valid[k] && req_ready[k]) begin
          tr_id.push_back(k);
          tr_cyc.push_back(cyc);
        end
      if (rsp_valid && rsp_ready) begin
        if (rsp_id == 2'd3) n_pop3++;
        if (rsp_trunc) n_trunc++;
      end
      if (pop) void'(exp_q.pop_front());
      if (xfer) begin
        m_beats++;
        fin_burst = req_last[m_g] || (m_beats == MAXBEAT);
        r.word  = req_data[14*m_g +: 14];
        r.data  = alu_ref(r.word);
        r.id    = m_g;
        r.last  = fin_burst;
        r.trunc = fin_burst && !req_last[m_g];
        r.t     = cyc;
        exp_q.push_back(r);
        void'(src[m_g].pop_front());
        if (fin_burst) begin
          m_ptr  = (m_g + 1) % NREQ;
          m_busy = 1'b0;
        end
      end else if (!m_busy) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!m_busy && req_valid[(m_ptr + i) % NREQ]) begin
            m_g     = (m_ptr + i) % NREQ;
            m_busy  = 1'b1;
            m_beats = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      prep();
      fin();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    prep();
    fin();
    rst = 1'b0;
    live = 1'b1;
    tr_id.delete();
    tr_cyc.delete();
    n_pop3 = 0;
    n_trunc = 0;
  endtask

  initial begin
    int exp_rr[5];
    int exp_mb[13];
    int left;
    beat_t b;
    exp_rr = '{0, 1, 2, 3, 0};
    exp_mb = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3, 2, 2};
    ncmp = 0; nfail = 0; cyc = 0; live = 1'b0;
    rst = 1'b1; en = '1; rr = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; rsp_ready = 1'b1;
    m_busy = 1'b0; m_g = 0; m_ptr = 0; m_beats = 0;

    // Single beat after reset: reset values, grant in cycle 2, response after LAT
    do_reset();
    b.word = 14'h2A5C; b.last = 1'b1;
    src[0].push_back(b);
    prep();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_alu_in", 32'(alu_in), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_last", 32'(rsp_last), 32'h0);
    chk("rst_rsp_trunc", 32'(rsp_trunc), 32'h0);
    fin();
    prep();
    chk("t1_grant_cycle2", 32'(req_ready), 32'h1);
    fin();
    step(LAT - 1);
    prep();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_data", 32'(rsp_data), 32'(alu_ref(14'h2A5C)));
    chk("t1_rsp_id", 32'(rsp_id), 32'h0);
    chk("t1_rsp_last", 32'(rsp_last), 32'h1);
    chk("t1_rsp_trunc", 32'(rsp_trunc), 32'h0);
    fin();
    step(3);

    // All four requesters with single-beat bursts: 0,1,2,3,0 with an idle between
    do_reset();
    for (int r2 = 0; r2 < 2; r2++)
      for (int k = 0; k < NREQ; k++) push_burst(k, 1, 1'b1);
    step(22);
    chk("rr_count", 32'(tr_id.size()), 32'd8);
    if (tr_id.size() >= 5)
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", 32'(tr_id[i]), 32'(exp_rr[i]));
        if (i < 4) chk("rr_gap", 32'(tr_cyc[i+1] - tr_cyc[i]), 32'd2);
      end

    // Requester 2 streams 10 beats with no last: truncated at MAXBEAT, others served first
    do_reset();
    push_burst(2, 10, 1'b0);
    push_burst(0, 1, 1'b1);
    push_burst(1, 1, 1'b1);
    push_burst(3, 1, 1'b1);
    step(26);
    chk("mb_count", 32'(tr_id.size()), 32'd13);
    chk("mb_trunc", 32'(n_trunc), 32'd1);
    if (tr_id.size() == 13)
      for (int i = 0; i < 13; i++) chk("mb_order", 32'(tr_id[i]), 32'(exp_mb[i]));

    // Response stall of 5 cycles during a 4-beat burst
    do_reset();
    push_burst(3, 4, 1'b1);
    rr = 1'b1;
    step(2);
    rr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      prep();
      if (i >= 2) begin
        chk("stall_ready", 32'(req_ready), 32'h0);
        chk("stall_valid", 32'(rsp_valid), 32'h1);
      end
      fin();
    end
    rr = 1'b1;
    step(8);
    chk("stall_pops", 32'(n_pop3), 32'd4);

    // Reset during beat 3 of a 6-beat burst, then a fresh burst from requester 1
    do_reset();
    push_burst(0, 6, 1'b1);
    step(3);
    rst = 1'b1;
    prep();
    fin();
    rst = 1'b0;
    tr_id.delete(); tr_cyc.delete(); n_trunc = 0;
    prep();
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_alu_in", 32'(alu_in), 32'h0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("mid_rst_rsp_last", 32'(rsp_last), 32'h0);
    chk("mid_rst_rsp_trunc", 32'(rsp_trunc), 32'h0);
    fin();
    push_burst(1, 8, 1'b0);
    step(14);
    chk("regrant_beats", 32'(tr_id.size()), 32'd8);
    chk("regrant_trunc", 32'(n_trunc), 32'd1);
    if (tr_id.size() == 8) chk("regrant_id", 32'(tr_id[7]), 32'd1);

    // Randomized traffic with valid gaps and response back-pressure
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0)
        push_burst(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(1, 12)), 1'b1);
      for (int k = 0; k < NREQ; k++) en[k] = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      step(1);
    end
    en = '1;
    rr = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      left = exp_q.size();
      for (int k = 0; k < NREQ; k++) left += src[k].size();
      if (left != 0) step(1);
    end
    left = exp_q.size();
    for (int k = 0; k < NREQ; k++) left += src[k].size();
    chk("rand_drained", 32'(left), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
